// File: rtl/umem_pkg.sv
// Shared types and constants for the umem block.
package umem_pkg;

  localparam int unsigned UMEM_AW    = 8;
  localparam int unsigned UMEM_DW    = 8;
  localparam int unsigned UMEM_DEPTH = 1 << UMEM_AW;

  // Address reserved for the memory-mapped I/O byte when UMEM_IO_PORT_EN is defined.
  localparam logic [UMEM_AW-1:0] UMEM_IO_ADDR = 8'hFF;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } umem_state_e;

endpackage

// File: rtl/umem_array.sv
// 256 x 8 storage: one synchronous write port, one asynchronous read port.
// Contents are not reset; the umem clear sequence zeroes them after reset.
module umem_array
  import umem_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [UMEM_AW-1:0] waddr,
  input  logic [UMEM_DW-1:0] wdata,
  input  logic [UMEM_AW-1:0] raddr,
  output logic [UMEM_DW-1:0] rdata
);

  logic [UMEM_DW-1:0] mem [UMEM_DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/umem.sv
// umem: 256-byte CPU-attached memory with a post-reset clear sequence, registered read
// address and a tri-stated data bus.
// Optional feature: define UMEM_IO_PORT_EN to map address 0xFF onto io_in/io_out.
module umem
  import umem_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic [UMEM_AW-1:0] o_a,
  inout  wire  [UMEM_DW-1:0] o_d,
  input  logic               ram_wc,
  input  logic               ram_rc,
  output logic               busy,
  output logic               bus_err,
  input  logic [UMEM_DW-1:0] io_in,
  output logic [UMEM_DW-1:0] io_out
);

  umem_state_e        state_q, state_d;
  logic [UMEM_AW-1:0] cnt_q, cnt_d;
  logic [UMEM_AW-1:0] addr_q;
  logic               bus_err_q;

  logic               run;
  logic               wr_req;
  logic               conflict;
  logic               io_hit_w;
  logic               arr_we;
  logic [UMEM_AW-1:0] arr_waddr;
  logic [UMEM_DW-1:0] arr_wdata;
  logic [UMEM_DW-1:0] arr_rdata;
  logic [UMEM_DW-1:0] rd_data;

  assign run      = (state_q == RUN);
  assign wr_req   = ram_wc & ~ram_rc;
  assign conflict = ram_wc & ram_rc;

  // Next state, clear counter and storage write port selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_waddr = o_a;
    arr_wdata = o_d;
    unique case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q;
        arr_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        // Last location written this cycle; counter wrap is harmless since RUN holds it.
        if (&cnt_q) begin
          state_d = RUN;
        end
      end
      RUN: begin
        arr_we = wr_req & ~io_hit_w;
      end
    endcase
  end

  // State and clear counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Read address register, loaded every RUN cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
    end else if (run) begin
      addr_q <= o_a;
    end
  end

  // Sticky bus conflict flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus_err_q <= 1'b0;
    end else if (run && conflict) begin
      bus_err_q <= 1'b1;
    end
  end

`ifdef UMEM_IO_PORT_EN
  logic [UMEM_DW-1:0] io_out_q;

  assign io_hit_w = (o_a == UMEM_IO_ADDR);
  assign rd_data  = (addr_q == UMEM_IO_ADDR) ? io_in : arr_rdata;
  assign io_out   = io_out_q;

  // Output register takes RUN writes aimed at the I/O address instead of storage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      io_out_q <= '0;
    end else if (run && wr_req && io_hit_w) begin
      io_out_q <= o_d;
    end
  end
`else
  logic unused_io_in;

  assign io_hit_w     = 1'b0;
  assign rd_data      = arr_rdata;
  assign io_out       = '0;
  assign unused_io_in = ^io_in;
`endif

  umem_array u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (addr_q),
    .rdata (arr_rdata)
  );

  // Drive the bus only for RUN reads; released during clear and reset.
  assign o_d     = (run && ram_rc) ? rd_data : {UMEM_DW{1'bz}};
  assign busy    = ~run;
  assign bus_err = bus_err_q;

endmodule

// File: tb/tb_umem.sv
// Self-checking bench for umem: directed vector table, multi-cycle reset/clear sequences,
// and randomized traffic against a behavioural memory model.
// o_d is pulled up, so a released bus reads as 8'hFF.
module tb_umem;

`ifdef UMEM_IO_PORT_EN
  localparam bit IO_EN = 1'b1;
`else
  localparam bit IO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] o_a;
  logic       ram_wc;
  logic       ram_rc;
  logic       busy;
  logic       bus_err;
  logic [7:0] io_in;
  logic [7:0] io_out;
  logic [7:0] cpu_d;
  logic       cpu_oe;
  tri1  [7:0] o_d;

  assign o_d = cpu_oe ? cpu_d : 8'hzz;

  umem dut (
    .clk     (clk),
    .rstn    (rstn),
    .o_a     (o_a),
    .o_d     (o_d),
    .ram_wc  (ram_wc),
    .ram_rc  (ram_rc),
    .busy    (busy),
    .bus_err (bus_err),
    .io_in   (io_in),
    .io_out  (io_out)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model of the RUN-mode memory.
  logic [7:0] mem_m [256];
  logic       err_m;
  logic [7:0] io_m;

  typedef struct {
    logic       wc;
    logic       rc;
    logic [7:0] a;
    logic [7:0] d;
    logic       chk_d;
    logic [7:0] exp_d;
    logic       exp_err;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", name, got, exp);
    end
  endtask

  task automatic drive(input logic wc, input logic rc, input logic [7:0] a,
                       input logic [7:0] d);
    ram_wc = wc;
    ram_rc = rc;
    o_a    = a;
    cpu_d  = d;
    cpu_oe = wc;
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 256; i++) mem_m[i] = 8'h00;
    err_m = 1'b0;
    io_m  = 8'h00;
  endfunction

  function automatic void model_edge(input logic wc, input logic rc, input logic [7:0] a,
                                     input logic [7:0] d);
    if (wc && rc) err_m = 1'b1;
    else if (wc) begin
      if (IO_EN && a == 8'hFF) io_m = d;
      else mem_m[a] = d;
    end
  endfunction

  function automatic logic [7:0] exp_bus(input logic rc, input logic [7:0] a);
    if (!rc) return 8'hFF;
    if (IO_EN && a == 8'hFF) return io_in;
    return mem_m[a];
  endfunction

  // Pulse reset from a negedge and check the asynchronous reset values.
  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    rstn = 1'b0;
    #2;
    check("reset/busy", {7'b0, busy}, 8'h01);
    check("reset/bus_err", {7'b0, bus_err}, 8'h00);
    check("reset/io_out", io_out, 8'h00);
    check("reset/o_d_released", o_d, 8'hFF);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  // Walk one full clear sequence; optionally attempt a write at cycle write_at.
  task automatic clear_run(input string tag, input logic rc, input int write_at);
    for (int i = 0; i < 256; i++) begin
      check({tag, "/busy_during_clear"}, {7'b0, busy}, 8'h01);
      if (rc) check({tag, "/o_d_during_clear"}, o_d, 8'hFF);
      if (i == write_at) drive(1'b1, 1'b0, 8'h05, 8'h77);
      else drive(1'b0, rc, 8'h00, 8'h00);
      @(posedge clk);
      @(negedge clk);
    end
    check({tag, "/busy_after_clear"}, {7'b0, busy}, 8'h00);
    drive(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn  = 1'b1;
    io_in = 8'h00;
    drive(1'b0, 1'b0, 8'h00, 8'h00);

    // Power-up reset, then a clear with the read strobe held high.
    do_reset();
    clear_run("clear1", 1'b1, -1);

    io_in = 8'hC3;
    vecs.push_back('{1'b1, 1'b0, 8'h10, 8'hA5, 1'b0, 8'h00, 1'b0, "wr_10"});
    vecs.push_back('{1'b0, 1'b1, 8'h10, 8'h00, 1'b1, 8'hA5, 1'b0, "rd_10"});
    vecs.push_back('{1'b0, 1'b0, 8'h10, 8'h00, 1'b1, 8'hFF, 1'b0, "idle_release"});
    vecs.push_back('{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h00, 1'b0, "rd_00_cleared"});
    vecs.push_back('{1'b0, 1'b1, 8'h80, 8'h00, 1'b1, 8'h00, 1'b0, "rd_80_cleared"});
    vecs.push_back('{1'b0, 1'b1, 8'hFE, 8'h00, 1'b1, 8'h00, 1'b0, "rd_fe_cleared"});
    vecs.push_back('{1'b1, 1'b1, 8'h20, 8'h5A, 1'b0, 8'h00, 1'b1, "conflict_20"});
    vecs.push_back('{1'b0, 1'b1, 8'h20, 8'h00, 1'b1, 8'h00, 1'b1, "rd_20_unchanged"});
    vecs.push_back('{1'b1, 1'b0, 8'hFF, 8'h3C, 1'b0, 8'h00, 1'b1, "wr_ff"});
    vecs.push_back('{1'b0, 1'b1, 8'hFF, 8'h00, 1'b1, IO_EN ? 8'hC3 : 8'h3C, 1'b1, "rd_ff"});
    vecs.push_back('{1'b1, 1'b0, 8'h7E, 8'h81, 1'b0, 8'h00, 1'b1, "wr_7e"});
    vecs.push_back('{1'b0, 1'b1, 8'h7E, 8'h00, 1'b1, 8'h81, 1'b1, "rd_7e"});

    foreach (vecs[i]) begin
      drive(vecs[i].wc, vecs[i].rc, vecs[i].a, vecs[i].d);
      @(posedge clk);
      @(negedge clk);
      if (vecs[i].chk_d) check({vecs[i].name, "/o_d"}, o_d, vecs[i].exp_d);
      check({vecs[i].name, "/bus_err"}, {7'b0, bus_err}, {7'b0, vecs[i].exp_err});
    end
    check("io_out_after_wr_ff", io_out, IO_EN ? 8'h3C : 8'h00);

    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (10) @(negedge clk);
    check("bus_err_sticky", {7'b0, bus_err}, 8'h01);

    // Reset in the middle of a clear restarts the full 256-cycle sequence.
    do_reset();
    drive(1'b0, 1'b0, 8'h00, 8'h00);
    repeat (100) @(negedge clk);
    check("midclear/busy_at_100", {7'b0, busy}, 8'h01);
    rstn = 1'b0;
    #2;
    check("midclear/bus_err", {7'b0, bus_err}, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    clear_run("clear2", 1'b0, 10);

    // The write issued during clear must not have landed.
    drive(1'b0, 1'b1, 8'h05, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("rd_05_after_clear_write", o_d, 8'h00);

    // Randomized RUN traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic       wc, rc;
      logic [7:0] a, d;
      wc = ($urandom_range(0, 2) == 0);
      rc = wc ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 1) == 1);
      a  = ($urandom_range(0, 4) == 0) ? 8'hFF : 8'h40 + 8'($urandom_range(0, 7));
      d  = 8'($urandom);
      io_in = 8'($urandom);
      drive(wc, rc, a, d);
      @(posedge clk);
      model_edge(wc, rc, a, d);
      @(negedge clk);
      if (!wc) check("rand/o_d", o_d, exp_bus(rc, a));
      check("rand/bus_err", {7'b0, bus_err}, {7'b0, err_m});
      check("rand/io_out", io_out, IO_EN ? io_m : 8'h00);
    end

    drive(1'b0, 1'b0, 8'h00, 8'h00);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/umem.md
UMEM -- requirements
Module: umem

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port o_a  input  8  bus address from CPU.
REQ-004 SHALL have port o_d  inout  8  bidirectional data bus; umem drives only when reading, otherwise high-Z.
REQ-005 SHALL have port ram_wc  input  1  write request, active-high.
REQ-006 SHALL have port ram_rc  input  1  read request, active-high; CPU releases o_d while ram_rc=1.
REQ-007 SHALL have port busy  output  1  high while post-reset clear is in progress.
REQ-008 SHALL have port bus_err  output  1  sticky flag: ram_wc and ram_rc were sampled high together.
REQ-009 SHALL have port io_in  input  8  external input byte (used only with UMEM_IO_PORT_EN).
REQ-010 SHALL have port io_out  output  8  external output register (used only with UMEM_IO_PORT_EN).

Function
REQ-011 SHALL hold 256 x 8-bit storage addressed by o_a.
REQ-012 SHALL have FSM states CLEAR and RUN; reset enters CLEAR with clear counter = 0.
REQ-013 In CLEAR, SHALL write 0x00 to location counter each cycle, increment the counter, and enter RUN after writing location 255 (256 cycles; busy=1 throughout, busy=0 from the first RUN cycle).
REQ-014 In CLEAR, SHALL ignore bus writes and keep o_d high-Z regardless of ram_rc.
REQ-015 In RUN, SHALL register o_a into addr_q on every rising edge.
REQ-016 In RUN, ram_wc=1 and ram_rc=0 at a rising edge SHALL write o_d into location o_a at that edge.
REQ-017 In RUN, while ram_rc=1, o_d SHALL be driven combinationally with the content of addr_q (one-cycle read latency from address presentation).
REQ-018 Read-after-write to the same address on the next cycle SHALL return the newly written value.
REQ-019 ram_wc=1 and ram_rc=1 at the same edge SHALL suppress the write, still perform the read, and set bus_err.
REQ-020 bus_err SHALL stay set until reset.
REQ-021 Counter and addresses are 8-bit; the clear counter SHALL NOT wrap back into CLEAR after 255.

Reset
REQ-022 On rstn=0, asynchronously: state=CLEAR, clear counter=0, addr_q=0x00, bus_err=0, io_out=0x00, o_d high-Z; busy=1.
REQ-023 Reset asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from location 0; storage contents are not guaranteed until CLEAR completes.

Configuration
REQ-024 Macro UMEM_IO_PORT_EN defined: address 0xFF SHALL be memory-mapped I/O; a RUN write to 0xFF loads io_out (storage unchanged); a read of 0xFF drives io_in.
REQ-025 Macro UMEM_IO_PORT_EN undefined: 0xFF SHALL be ordinary storage, io_out SHALL be constant 0x00, and io_in SHALL be ignored.

Structure
REQ-026 A shared package umem_pkg SHALL hold the state enum (CLEAR, RUN), UMEM_AW=8, UMEM_DW=8, and UMEM_IO_ADDR=8'hFF.
REQ-027 Storage SHALL be the sub-module umem_array: one synchronous write port, one asynchronous read port. FSM, bus drive, and I/O logic SHALL stay in umem.

Verification
REQ-028 Clear: release rstn, hold ram_rc=1 -> busy=1 and o_d=Z for 256 cycles; then busy=0, and a read of addresses 0x00, 0x80, 0xFE returns 0x00.
REQ-029 Write/read: write 0xA5 to 0x10, then present 0x10 with ram_rc=1 -> o_d=0xA5 one cycle after the address; ram_rc=0 -> o_d=Z.
REQ-030 Conflict: ram_wc=ram_rc=1 at 0x20 with CPU data 0x5A -> location 0x20 unchanged (0x00), bus_err=1 and still 1 after 10 idle cycles.
REQ-031 Mid-CLEAR reset: assert rstn=0 at clear count 100, then release -> busy stays 1 for a full 256 cycles again.
REQ-032 I/O with UMEM_IO_PORT_EN: write 0x3C to 0xFF -> io_out=0x3C; io_in=0xC3, read 0xFF -> o_d=0xC3. Without the macro: read-back of 0xFF = 0x3C and io_out=0x00.
REQ-033 Write during CLEAR: ram_wc=1 to 0x05 with data 0x77 at cycle 10 -> after CLEAR, read 0x05 = 0x00.
